// File: rtl/array_issue_queue.sv
// array_issue_queue
//   In-order issue queue plus vector-register scoreboard for the array
//   extension. Buffers array instructions from decode in a circular FIFO and
//   dispatches the head entry over DP_valid/DP_ready once the registered
//   scoreboard shows none of its vector operands (or its rd) pending.
// Ports
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   ID_*                decode request: opcode, vregs, base address, stride
//   ID_isIssue          decode holds an array instruction
//   ID_busy             queue full; request not accepted this cycle
//   DP_*                head entry and its valid/ready dispatch handshake
//   CM_valid, CM_rd     retirement of a vreg write, clears its pending bit
//   Q_count             occupancy 0..DEPTH
module array_issue_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       ID_opcode,
  input  logic [4:0]       ID_rd,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [WIDTH-1:0] ID_regval1,
  input  logic [WIDTH-1:0] ID_regval2,
  input  logic             ID_isIssue,
  output logic             ID_busy,
  output logic             DP_valid,
  input  logic             DP_ready,
  output logic [6:0]       DP_opcode,
  output logic [4:0]       DP_rd,
  output logic [4:0]       DP_rs1,
  output logic [4:0]       DP_rs2,
  output logic [WIDTH-1:0] DP_addr,
  output logic [WIDTH-1:0] DP_stride,
  input  logic             CM_valid,
  input  logic [4:0]       CM_rd,
  output logic [AW:0]      Q_count
);

  localparam logic [6:0] OP_ADD   = 7'b1111000;
  localparam logic [6:0] OP_MULT  = 7'b1111001;
  localparam logic [6:0] OP_LOAD  = 7'b1111010;
  localparam logic [6:0] OP_STORE = 7'b1111011;
  localparam logic [6:0] OP_RELU  = 7'b1111100;

  logic [6:0]       op_mem     [DEPTH];
  logic [4:0]       rd_mem     [DEPTH];
  logic [4:0]       rs1_mem    [DEPTH];
  logic [4:0]       rs2_mem    [DEPTH];
  logic [WIDTH-1:0] addr_mem   [DEPTH];
  logic [WIDTH-1:0] stride_mem [DEPTH];

  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [31:0]   scoreboard;

  logic full, empty, is_array, enq, deq;
  logic [6:0] h_op;
  logic [4:0] h_rd, h_rs1, h_rs2;
  logic reads_rs1, reads_rs2, writes_rd, blocked;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    is_array = 1'b0;
    case (ID_opcode)
      OP_ADD, OP_MULT, OP_LOAD, OP_STORE, OP_RELU: is_array = 1'b1;
      default: is_array = 1'b0;
    endcase
  end

  assign enq = ID_isIssue & ~full & is_array;

  assign h_op  = op_mem[head];
  assign h_rd  = rd_mem[head];
  assign h_rs1 = rs1_mem[head];
  assign h_rs2 = rs2_mem[head];

  // LOAD's rs1 names a scalar register, so it never consults the scoreboard.
  assign reads_rs1 = (h_op == OP_ADD) | (h_op == OP_MULT) |
                     (h_op == OP_RELU) | (h_op == OP_STORE);
  assign reads_rs2 = (h_op == OP_ADD) | (h_op == OP_MULT);
  assign writes_rd = (h_op != OP_STORE);

  assign blocked = (reads_rs1 & scoreboard[h_rs1]) |
                   (reads_rs2 & scoreboard[h_rs2]) |
                   (writes_rd & scoreboard[h_rd]);

  assign DP_valid  = ~empty & ~blocked;
  assign deq       = DP_valid & DP_ready;
  assign ID_busy   = full;
  assign Q_count   = count;

  assign DP_opcode = empty ? '0 : h_op;
  assign DP_rd     = empty ? '0 : h_rd;
  assign DP_rs1    = empty ? '0 : h_rs1;
  assign DP_rs2    = empty ? '0 : h_rs2;
  assign DP_addr   = empty ? '0 : addr_mem[head];
  assign DP_stride = empty ? '0 : stride_mem[head];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_mem[i]     <= '0;
        rd_mem[i]     <= '0;
        rs1_mem[i]    <= '0;
        rs2_mem[i]    <= '0;
        addr_mem[i]   <= '0;
        stride_mem[i] <= '0;
      end
    end else begin
      if (enq) begin
        op_mem[tail]     <= ID_opcode;
        rd_mem[tail]     <= ID_rd;
        rs1_mem[tail]    <= ID_rs1;
        rs2_mem[tail]    <= ID_rs2;
        addr_mem[tail]   <= ID_regval1;
        stride_mem[tail] <= ID_regval2;
        tail             <= tail + 1'b1;
      end
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Clear is applied before set so a dispatch and a completion of the same
  // vreg on one edge leave the bit pending.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scoreboard <= '0;
    end else begin
      logic [31:0] sb_n;
      sb_n = scoreboard;
      if (CM_valid) sb_n[CM_rd] = 1'b0;
      if (deq && writes_rd) sb_n[h_rd] = 1'b1;
      scoreboard <= sb_n;
    end
  end

endmodule
